// File: rtl/clksw_pkg.sv
// Shared definitions for the clock-switch controller: FSM state encoding and parameter defaults.
package clksw_pkg;

  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_BREAK_ENC = 2'd1;
  localparam logic [1:0] ST_MAKE_ENC  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE_ENC,
    S_BREAK = ST_BREAK_ENC,
    S_MAKE  = ST_MAKE_ENC
  } state_t;

  localparam int TO_MAX_DEF = 200;
  localparam int TO_W_DEF   = 8;
  localparam int SYNC_N_MIN = 2;

endpackage

// File: rtl/clksw_ctrl_sync_ff.sv
// N-flop synchroniser bringing one asynchronous valid flag into the reference clock domain.
module sync_ff
  import clksw_pkg::*;
#(
  parameter int N = SYNC_N_MIN
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [N-1:0] r_sh;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sh <= '0;
    end else begin
      r_sh <= {r_sh[N-2:0], i_d};
    end
  end

  assign o_q = r_sh[N-1];

endmodule

// File: rtl/clksw_ctrl.sv
// Break-before-make controller for the glitch-free clock switch (select, confirm, status).
// Optional phase timeout with revert is built when CLKSW_CTRL_TIMEOUT_EN is defined.
module clksw_ctrl
  import clksw_pkg::*;
#(
  parameter logic INIT   = 1'b0,
  parameter int   SYNC_N = SYNC_N_MIN,
  parameter int   TO_W   = TO_W_DEF,
  parameter int   TO_MAX = TO_MAX_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_req,
  input  logic       i_req_src,
  input  logic [1:0] i_vld,
  output logic       o_sel,
  output logic       o_cur_src,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err
);

  if (SYNC_N < SYNC_N_MIN) begin : g_chk_sync
    $error("clksw_ctrl: SYNC_N must be at least 2");
  end
  if ((TO_W < 1) || (TO_MAX < 1) || (TO_W < 31 && TO_MAX >= (1 << TO_W))) begin : g_chk_to
    $error("clksw_ctrl: TO_MAX must fit in TO_W bits");
  end

  logic [1:0] w_vs;

  for (genvar gi = 0; gi < 2; gi++) begin : g_sync
    sync_ff #(.N(SYNC_N)) u_sync (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_d   (i_vld[gi]),
      .o_q   (w_vs[gi])
    );
  end

  state_t r_state, w_state_next;
  logic   r_sel, w_sel_next;
  logic   r_cur, w_cur_next;
  logic   r_busy, w_busy_next;
  logic   r_done, w_done_next;

`ifdef CLKSW_CTRL_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TO_MAX);
  logic            r_err, w_err_next;
  logic [TO_W-1:0] r_timer, w_timer_next;
`endif

  always_comb begin
    w_state_next = r_state;
    w_sel_next   = r_sel;
    w_cur_next   = r_cur;
    w_busy_next  = r_busy;
    w_done_next  = 1'b0;
`ifdef CLKSW_CTRL_TIMEOUT_EN
    w_err_next   = 1'b0;
    w_timer_next = r_timer;
`endif
    case (r_state)
      S_IDLE: begin
        if (i_req) begin
          if (i_req_src == r_cur) begin
            w_done_next = 1'b1;
          end else begin
            w_sel_next   = i_req_src;
            w_busy_next  = 1'b1;
            w_state_next = S_BREAK;
`ifdef CLKSW_CTRL_TIMEOUT_EN
            w_timer_next = '0;
`endif
          end
        end
      end
      S_BREAK: begin
        // completion is tested first so it wins over a timeout in the same cycle
        if (!w_vs[r_cur]) begin
          w_state_next = S_MAKE;
`ifdef CLKSW_CTRL_TIMEOUT_EN
          w_timer_next = '0;
`endif
        end
`ifdef CLKSW_CTRL_TIMEOUT_EN
        else if (r_timer == TO_LIM) begin
          w_sel_next   = r_cur;
          w_busy_next  = 1'b0;
          w_err_next   = 1'b1;
          w_timer_next = '0;
          w_state_next = S_IDLE;
        end else begin
          w_timer_next = r_timer + 1'b1;
        end
`endif
      end
      S_MAKE: begin
        if (w_vs[r_sel]) begin
          w_cur_next   = r_sel;
          w_busy_next  = 1'b0;
          w_done_next  = 1'b1;
          w_state_next = S_IDLE;
        end
`ifdef CLKSW_CTRL_TIMEOUT_EN
        else if (r_timer == TO_LIM) begin
          w_sel_next   = r_cur;
          w_busy_next  = 1'b0;
          w_err_next   = 1'b1;
          w_timer_next = '0;
          w_state_next = S_IDLE;
        end else begin
          w_timer_next = r_timer + 1'b1;
        end
`endif
      end
      default: begin
        w_sel_next   = r_cur;
        w_busy_next  = 1'b0;
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_sel   <= INIT;
      r_cur   <= INIT;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_sel   <= w_sel_next;
      r_cur   <= w_cur_next;
      r_busy  <= w_busy_next;
      r_done  <= w_done_next;
    end
  end

`ifdef CLKSW_CTRL_TIMEOUT_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_err   <= 1'b0;
      r_timer <= '0;
    end else begin
      r_err   <= w_err_next;
      r_timer <= w_timer_next;
    end
  end

  assign o_err = r_err;
`else
  assign o_err = 1'b0;
`endif

  assign o_sel     = r_sel;
  assign o_cur_src = r_cur;
  assign o_busy    = r_busy;
  assign o_done    = r_done;

endmodule
